scancode_event_fifo: RTL and testbench
======================================

# scancode_event_fifo

Event buffer between the PS/2 receive path and the CPU-visible scancode register. It captures every decoded scancode event (code byte, extended flag, released flag) on the receiver's one-cycle strobe and queues it in a small FIFO. The CPU can then drain events at its own pace without losing keystrokes between reads. Typematic repeats of a held key are optionally filtered out before queuing.

## Interface
- DEPTH_LOG2, 4, log2 of FIFO depth (16 entries); legal range 2..6
- FILTER_REPEAT, 1, 1 = drop auto-repeat make codes; 0 = queue every event
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- scan_received  in  1  one-cycle strobe: new event valid on scancode/extended/released
- scancode  in  8  scancode byte (sampled only when scan_received=1)
- extended  in  1  E0 prefix seen for this event
- released  in  1  F0 prefix seen for this event (break code)
- cpu_read  in  1  level, high while the CPU reads the scancode register (may span several cycles)
- clear  in  1  one-cycle synchronous flush request
- head_scancode  out  8  oldest queued code; 8'h00 when empty
- head_extended  out  1  extended flag of oldest entry; 0 when empty
- head_released  out  1  released flag of oldest entry; 0 when empty
- not_empty  out  1  at least one entry queued
- overflow  out  1  sticky: an event was dropped because the FIFO was full
- count  out  DEPTH_LOG2+1  number of queued entries, 0..2^DEPTH_LOG2

## Operation
- Storage: 2^DEPTH_LOG2 entries × 10 bits, {extended, released, scancode}.
  - Write pointer wp and read pointer rp are DEPTH_LOG2 bits wide and wrap modulo depth.
  - count is kept in its own register, DEPTH_LOG2+1 bits.
  - Head outputs are the entry at rp, gated to zero when count==0.
- Pop detection: register cpu_read into cpu_read_d. pop = cpu_read_d & ~cpu_read, i.e. the falling edge that ends the read access. Exactly one pop per read access, however long the access lasts.
- Push request: scan_received, unless the repeat filter drops the event.
- Repeat filter (FILTER_REPEAT=1): registers last_valid and last_key={extended, scancode}.
  - Make event (released=0) with last_valid=1 and {extended,scancode}==last_key: dropped. It is not queued and does not set overflow.
  - Make event not dropped and actually queued: last_key <= {extended,scancode}, last_valid <= 1.
  - Break event (released=1): always queued (subject to full). If {extended,scancode}==last_key, last_valid <= 0.
  - last_key/last_valid update only when the event is actually written to the FIFO.
  - FILTER_REPEAT=0: filter logic is inert; every strobe is a push request.
- Per-cycle resolution, in priority order:
  1. clear=1: wp<=0, rp<=0, count<=0, overflow<=0, last_valid<=0. Any push or pop in the same cycle is discarded.
  2. Push and pop, count==0: push only; pop ignored; count<=1.
  3. Push and pop, count==full: both happen; count unchanged; overflow unchanged.
  4. Push and pop, 0<count<full: both happen; count unchanged.
  5. Push only, count<full: write at wp, wp++, count++.
  6. Push only, count==full: event dropped, overflow<=1, no pointer change.
  7. Pop only, count>0: rp++, count--.
  8. Pop only, count==0: no effect.
- Reset (asynchronous, any time): wp=rp=0, count=0, overflow=0, last_valid=0, cpu_read_d=0.
  - All outputs read 0 on reset: head_scancode=8'h00, head_extended=0, head_released=0, not_empty=0, overflow=0, count=0.
  - Memory contents are don't-care.
  - Reset during a CPU read: the following falling edge of cpu_read is still a pop request, which is ignored because the FIFO is empty.

## Timing
- All state registered on posedge clk; no combinational path from scan_received to any output.
- Push latency: strobe at edge N → count/not_empty/head updated after edge N. Head is valid in cycle N+1 if the FIFO was empty.
- Pop latency: cpu_read falls in cycle M; cpu_read_d is still 1, so pop is asserted in cycle M. rp/count update at the end of cycle M, and the next entry appears in cycle M+1.
- Head is stable for the whole cpu_read access; it changes only after the access ends.
- Back-to-back strobes on consecutive cycles are accepted one per cycle.
- Wrap-around: pointers roll from depth-1 to 0 with no bubble.

## Test plan
- Reset then idle: all outputs 0. Strobe {code 8'h1C, ext 0, rls 0} → one cycle later head_scancode=8'h1C, not_empty=1, count=1.
- FIFO order: push 1C, F0-break 1C (rls=1), E0 75 (ext=1). Three 4-cycle cpu_read pulses return 1C/0/0, 1C/0/1, 75/1/0 in that order, then count=0 and not_empty=0.
- Repeat filter: five makes of 8'h1B then a break of 1B → count=2. Next make of 1B is queued (count=3). With FILTER_REPEAT=0, the first sequence gives count=6.
- Overflow with DEPTH_LOG2=2: push 5 distinct codes 01..05 → count=4, overflow=1, and the drained sequence is 01,02,03,04. clear → overflow=0, count=0.
- Simultaneous events: FIFO full (4 entries), strobe coinciding with the cpu_read falling edge → count stays 4, overflow stays 0, and the new code is last out. FIFO empty with the same coincidence → count=1.
- Async reset asserted mid-sequence (count=3, cpu_read high) → outputs 0 immediately, without waiting for a clock edge. After reset is released, the cpu_read falling edge leaves count=0.

Source files
------------

// File: rtl/scancode_event_fifo.sv
// scancode_event_fifo: queues decoded PS/2 scancode events for the CPU.
// Events are captured on the receiver strobe. Each completed CPU read access
// (the falling edge of cpu_read) pops one event. An optional filter drops
// typematic repeats of a held key.
module scancode_event_fifo #(
    parameter int unsigned DEPTH_LOG2    = 4,
    parameter int unsigned FILTER_REPEAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_received,
    input  logic [7:0]            scancode,
    input  logic                  extended,
    input  logic                  released,
    input  logic                  cpu_read,
    input  logic                  clear,
    output logic [7:0]            head_scancode,
    output logic                  head_extended,
    output logic                  head_released,
    output logic                  not_empty,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned PW    = DEPTH_LOG2;

    typedef struct packed {
        logic       extended;
        logic       released;
        logic [7:0] code;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic            cpu_read_d;
    logic            last_valid;
    logic [8:0]      last_key;

    logic [8:0]      key;
    logic            full;
    logic            empty;
    logic            pop;
    logic            drop;
    logic            push_req;
    logic            do_push;
    logic            do_pop;
    entry_t          head;

    // Decode push/pop requests and how each is resolved this cycle
    always_comb begin
        key      = {extended, scancode};
        full     = (count == CW'(DEPTH));
        empty    = (count == '0);
        pop      = cpu_read_d & ~cpu_read;
        drop     = (FILTER_REPEAT != 0) & ~released & last_valid & (key == last_key);
        push_req = scan_received & ~drop;
        // A push into a full FIFO succeeds only if it coincides with a pop
        do_push  = push_req & ~clear & (~full | pop);
        do_pop   = pop & ~empty & ~clear;
    end

    // Pointers, occupancy, sticky overflow, repeat-filter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp         <= '0;
            rp         <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            last_valid <= 1'b0;
            last_key   <= '0;
            cpu_read_d <= 1'b0;
        end else begin
            cpu_read_d <= cpu_read;
            if (clear) begin
                wp         <= '0;
                rp         <= '0;
                count      <= '0;
                overflow   <= 1'b0;
                last_valid <= 1'b0;
            end else begin
                if (do_push) begin
                    wp <= wp + PW'(1);
                end
                if (do_pop) begin
                    rp <= rp + PW'(1);
                end
                if (do_push && !do_pop) begin
                    count <= count + CW'(1);
                end else if (do_pop && !do_push) begin
                    count <= count - CW'(1);
                end
                if (push_req && full && !pop) begin
                    overflow <= 1'b1;
                end
                // Filter state follows only events that actually entered the FIFO
                if (do_push) begin
                    if (!released) begin
                        last_key   <= key;
                        last_valid <= 1'b1;
                    end else if (key == last_key) begin
                        last_valid <= 1'b0;
                    end
                end
            end
        end
    end

    // Event storage; contents need no reset because count gates the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= '{extended: extended, released: released, code: scancode};
        end
    end

    // Head of queue, forced to zero while empty
    always_comb begin
        head          = mem[rp];
        not_empty     = ~empty;
        head_scancode = empty ? 8'h00 : head.code;
        head_extended = empty ? 1'b0  : head.extended;
        head_released = empty ? 1'b0  : head.released;
    end

endmodule

// File: tb/tb_scancode_event_fifo.sv
// Testbench for scancode_event_fifo: three instances (16-deep filtered,
// 16-deep unfiltered, 4-deep filtered) share stimulus and are compared every
// cycle against a queue-based reference model.
module tb_scancode_event_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       scan_received;
    logic [7:0] scancode;
    logic       extended;
    logic       released;
    logic       cpu_read;
    logic       clear;

    logic [7:0] o_sc  [3];
    logic       o_ex  [3];
    logic       o_rl  [3];
    logic       o_ne  [3];
    logic       o_ov  [3];
    logic [4:0] o_cnt [3];
    logic [4:0] cnt_a;
    logic [4:0] cnt_b;
    logic [2:0] cnt_s;

    assign o_cnt[0] = cnt_a;
    assign o_cnt[1] = cnt_b;
    assign o_cnt[2] = {2'b00, cnt_s};

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [9:0] mq [3][$];
    bit         mlv  [3];
    logic [8:0] mlk  [3];
    bit         movf [3];
    bit         prev_read;

    always #5 clk = ~clk;

    scancode_event_fifo #(.DEPTH_LOG2(4), .FILTER_REPEAT(1)) dut_f (
        .clk(clk), .rst(rst), .scan_received(scan_received), .scancode(scancode),
        .extended(extended), .released(released), .cpu_read(cpu_read), .clear(clear),
        .head_scancode(o_sc[0]), .head_extended(o_ex[0]), .head_released(o_rl[0]),
        .not_empty(o_ne[0]), .overflow(o_ov[0]), .count(cnt_a));

    scancode_event_fifo #(.DEPTH_LOG2(4), .FILTER_REPEAT(0)) dut_nf (
        .clk(clk), .rst(rst), .scan_received(scan_received), .scancode(scancode),
        .extended(extended), .released(released), .cpu_read(cpu_read), .clear(clear),
        .head_scancode(o_sc[1]), .head_extended(o_ex[1]), .head_released(o_rl[1]),
        .not_empty(o_ne[1]), .overflow(o_ov[1]), .count(cnt_b));

    scancode_event_fifo #(.DEPTH_LOG2(2), .FILTER_REPEAT(1)) dut_s (
        .clk(clk), .rst(rst), .scan_received(scan_received), .scancode(scancode),
        .extended(extended), .released(released), .cpu_read(cpu_read), .clear(clear),
        .head_scancode(o_sc[2]), .head_extended(o_ex[2]), .head_released(o_rl[2]),
        .not_empty(o_ne[2]), .overflow(o_ov[2]), .count(cnt_s));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int depth_of(input int i);
        return (i == 2) ? 4 : 16;
    endfunction

    function automatic bit filt_of(input int i);
        return (i != 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            mlv[i]  = 0;
            mlk[i]  = '0;
            movf[i] = 0;
        end
        prev_read = 0;
    endtask

    // One clock of queue semantics, using inputs as seen at the edge
    task automatic model_step();
        bit         pop;
        bit         popok;
        bit         drop;
        logic [8:0] key;
        pop = prev_read && !cpu_read;
        key = {extended, scancode};
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                mq[i].delete();
                movf[i] = 0;
                mlv[i]  = 0;
            end else begin
                popok = pop && (mq[i].size() > 0);
                drop  = filt_of(i) && scan_received && !released && mlv[i] && (key == mlk[i]);
                if (popok) void'(mq[i].pop_front());
                if (scan_received && !drop) begin
                    if (mq[i].size() < depth_of(i)) begin
                        mq[i].push_back({extended, released, scancode});
                        if (!released) begin
                            mlk[i] = key;
                            mlv[i] = 1;
                        end else if (key == mlk[i]) begin
                            mlv[i] = 0;
                        end
                    end else begin
                        movf[i] = 1;
                    end
                end
            end
        end
        prev_read = cpu_read;
    endtask

    task automatic check_all();
        logic [9:0] e;
        for (int i = 0; i < 3; i++) begin
            e = (mq[i].size() > 0) ? mq[i][0] : 10'h000;
            check($sformatf("head_scancode[%0d]", i), 32'(o_sc[i]), 32'(e[7:0]));
            check($sformatf("head_extended[%0d]", i), 32'(o_ex[i]), 32'(e[9]));
            check($sformatf("head_released[%0d]", i), 32'(o_rl[i]), 32'(e[8]));
            check($sformatf("not_empty[%0d]", i), 32'(o_ne[i]), 32'(mq[i].size() > 0));
            check($sformatf("overflow[%0d]", i), 32'(o_ov[i]), 32'(movf[i]));
            check($sformatf("count[%0d]", i), 32'(o_cnt[i]), 32'(mq[i].size()));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic push(input logic [7:0] code, input logic ext, input logic rls);
        scancode      = code;
        extended      = ext;
        released      = rls;
        scan_received = 1'b1;
        tick();
        scan_received = 1'b0;
    endtask

    task automatic read_access(input int len);
        cpu_read = 1'b1;
        repeat (len) tick();
        cpu_read = 1'b0;
        tick();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        scan_received = 1'b0;
        scancode = 8'h00;
        extended = 1'b0;
        released = 1'b0;
        cpu_read = 1'b0;
        clear = 1'b0;
        model_reset();
        #3;
        check_all();
        #10 rst = 1'b0;
        repeat (2) tick();

        // first event appears one cycle after the strobe
        push(8'h1C, 1'b0, 1'b0);
        check("first_head", 32'(o_sc[0]), 32'h1C);
        check("first_count", 32'(o_cnt[0]), 32'd1);

        // FIFO order across make/break/extended events
        do_clear();
        push(8'h1C, 1'b0, 1'b0);
        push(8'h1C, 1'b0, 1'b1);
        push(8'h75, 1'b1, 1'b0);
        check("order_h0", 32'({o_sc[0], o_ex[0], o_rl[0]}), 32'({8'h1C, 1'b0, 1'b0}));
        read_access(4);
        check("order_h1", 32'({o_sc[0], o_ex[0], o_rl[0]}), 32'({8'h1C, 1'b0, 1'b1}));
        read_access(4);
        check("order_h2", 32'({o_sc[0], o_ex[0], o_rl[0]}), 32'({8'h75, 1'b1, 1'b0}));
        read_access(4);
        check("order_empty", 32'({o_cnt[0], o_ne[0]}), 32'h0);

        // repeat filter
        do_clear();
        repeat (5) push(8'h1B, 1'b0, 1'b0);
        push(8'h1B, 1'b0, 1'b1);
        check("filter_count", 32'(o_cnt[0]), 32'd2);
        check("nofilter_count", 32'(o_cnt[1]), 32'd6);
        push(8'h1B, 1'b0, 1'b0);
        check("filter_remake", 32'(o_cnt[0]), 32'd3);

        // overflow on the 4-deep instance
        do_clear();
        for (int k = 1; k <= 5; k++) push(8'(k), 1'b0, 1'b0);
        check("ovf_count", 32'(o_cnt[2]), 32'd4);
        check("ovf_flag", 32'(o_ov[2]), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_drain", 32'(o_sc[2]), 32'(k));
            read_access(2);
        end
        do_clear();
        check("ovf_cleared", 32'({o_ov[2], o_cnt[2]}), 32'h0);

        // push coinciding with pop while full
        for (int k = 0; k < 4; k++) push(8'h31 + 8'(k), 1'b0, 1'b0);
        cpu_read = 1'b1;
        tick();
        tick();
        cpu_read = 1'b0;
        push(8'h35, 1'b0, 1'b0);
        check("coinc_full_count", 32'(o_cnt[2]), 32'd4);
        check("coinc_full_ovf", 32'(o_ov[2]), 32'd0);
        repeat (3) read_access(1);
        check("coinc_last", 32'(o_sc[2]), 32'h35);

        // push coinciding with pop while empty
        do_clear();
        cpu_read = 1'b1;
        tick();
        cpu_read = 1'b0;
        push(8'h36, 1'b0, 1'b0);
        check("coinc_empty_count", 32'(o_cnt[0]), 32'd1);

        // asynchronous reset during a read access
        do_clear();
        for (int k = 0; k < 3; k++) push(8'h40 + 8'(k), 1'b0, 1'b0);
        cpu_read = 1'b1;
        tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        check("async_rst_count", 32'(o_cnt[0]), 32'd0);
        #1 rst = 1'b0;
        tick();
        cpu_read = 1'b0;
        tick();
        check("post_rst_count", 32'(o_cnt[0]), 32'd0);

        // randomized traffic with a small key set to exercise the filter
        repeat (3000) begin
            scan_received = ($urandom_range(0, 9) < 4);
            scancode      = 8'h1A + 8'($urandom_range(0, 3));
            extended      = ($urandom_range(0, 3) == 0);
            released      = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) cpu_read = ~cpu_read;
            clear         = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
